game_round_timer: RTL

- Round-timer controller for the crane game; generates its own one-second timebase from the 100 MHz clock.
- Sequences a per-round countdown: start, pause/resume, abort, expiry.
- Feeds seconds-remaining to the display path and a time-up pulse to the game FSM, which forces a claw drop.
- Owns the only prescaler in its path; no external one-second enable is used.

---
 rtl/game_round_timer_if.sv | 42 ++++
 rtl/game_round_timer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/game_round_timer_if.sv
// ---------------------------------------------------------------------------
// game_round_timer_if
// Bundles the control pulses and status outputs of the round timer.
//   start, pause_toggle, abort : single-cycle command pulses (master -> timer)
//   round_secs                 : round length, sampled only together with start
//   seconds_left               : remaining whole seconds
//   sec_tick, time_up          : single-cycle event pulses (timer -> master)
//   running, paused, expired   : one-hot state levels (all zero in IDLE)
//   warning                    : low-time indication while a round is live
//   state_dbg                  : raw state register, for observation only
// Handshake: there is no valid/ready pair. Every command is a one-cycle pulse
// that the timer accepts unconditionally on the rising edge where it is high,
// and every event output is a one-cycle pulse that the consumer must catch.
// ---------------------------------------------------------------------------
interface game_round_timer_if #(
    parameter int SEC_W = 8
);
    logic             start;
    logic             pause_toggle;
    logic             abort;
    logic [SEC_W-1:0] round_secs;
    logic [SEC_W-1:0] seconds_left;
    logic             sec_tick;
    logic             time_up;
    logic             running;
    logic             paused;
    logic             expired;
    logic             warning;
    logic [1:0]       state_dbg;

    modport master (
        output start, pause_toggle, abort, round_secs,
        input  seconds_left, sec_tick, time_up, running, paused, expired,
               warning, state_dbg
    );

    modport slave (
        input  start, pause_toggle, abort, round_secs,
        output seconds_left, sec_tick, time_up, running, paused, expired,
               warning, state_dbg
    );
endinterface

// File: rtl/game_round_timer.sv
// ---------------------------------------------------------------------------
// game_round_timer
// Crane-game round countdown with its own one-second prescaler.
//   clock_100Mhz : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   tmr          : slave side of game_round_timer_if (commands in, status out)
// Command priority on any edge: abort > start > pause_toggle.
// ---------------------------------------------------------------------------
module game_round_timer #(
    parameter int CYCLES_PER_SEC = 100000000,
    parameter int SEC_W          = 8,
    parameter int WARN_SECS      = 5
) (
    input logic                clock_100Mhz,
    input logic                reset_n,
    game_round_timer_if.slave  tmr
);
    localparam int PRE_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SEC_W-1:0] secs_q, secs_d;
    logic             tick_q, tick_d;
    logic             time_up_q, time_up_d;
    logic             terminal;

    assign terminal = (pre_q == PRE_LAST);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        secs_d    = secs_q;
        tick_d    = 1'b0;
        time_up_d = 1'b0;

        if (tmr.abort) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            secs_d  = '0;
        end else if (tmr.start) begin
            pre_d  = '0;
            secs_d = tmr.round_secs;
            if (tmr.round_secs == '0) begin
                state_d   = ST_EXPIRED;
                time_up_d = 1'b1;
            end else begin
                state_d = ST_RUNNING;
            end
        end else begin
            case (state_q)
                ST_RUNNING: begin
                    if (terminal && tmr.pause_toggle) begin
                        // Pause wins over the tick: the prescaler parks at
                        // terminal so the tick fires on the first edge after
                        // resume and the second keeps its full length.
                        state_d = ST_PAUSED;
                    end else if (terminal) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (secs_q != '0) begin
                            secs_d = secs_q - SEC_W'(1);
                        end
                        if (secs_q == SEC_W'(1)) begin
                            state_d   = ST_EXPIRED;
                            time_up_d = 1'b1;
                        end
                    end else begin
                        // The pausing edge still counts as a running cycle.
                        pre_d = pre_q + PRE_W'(1);
                        if (tmr.pause_toggle) begin
                            state_d = ST_PAUSED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (tmr.pause_toggle) begin
                        state_d = ST_RUNNING;
                    end
                end
                default: begin
                    pre_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            secs_q    <= '0;
            tick_q    <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            secs_q    <= secs_d;
            tick_q    <= tick_d;
            time_up_q <= time_up_d;
        end
    end

    assign tmr.seconds_left = secs_q;
    assign tmr.sec_tick     = tick_q;
    assign tmr.time_up      = time_up_q;
    assign tmr.running      = (state_q == ST_RUNNING);
    assign tmr.paused       = (state_q == ST_PAUSED);
    assign tmr.expired      = (state_q == ST_EXPIRED);
    assign tmr.state_dbg    = state_q;
    assign tmr.warning      = ((state_q == ST_RUNNING) || (state_q == ST_PAUSED))
                              && (secs_q != '0)
                              && (secs_q <= SEC_W'(WARN_SECS));
endmodule
